// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake and data bundle for bcd_serial_add_ctrl.
// The `sub` signal exists only when BCD_SUB_EN is defined.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;
  logic                  busy;
`ifdef BCD_SUB_EN
  logic                  sub;
`endif

  modport master (
`ifdef BCD_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err, busy
  );

  modport slave (
`ifdef BCD_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err, busy
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one shared digit stage walks the operands LSD first.
// Optional macro BCD_SUB_EN adds ten's-complement subtraction via a `sub` input.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_add_ctrl_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic [CW-1:0]     r_cnt;
  logic              r_carry;
  logic              r_cout;
  logic              r_err;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [CW+1:0]     w_base;
  logic [3:0]        w_a_dig;
  logic [3:0]        w_b_dig;
  logic [3:0]        w_b_eff;
  logic [4:0]        w_res;
  logic              w_bad;
  logic              w_last;
  logic              w_accept;
`ifdef BCD_SUB_EN
  logic              r_sub;
`endif

  // Returns {carry, digit}; the +6 correction is applied for any sum above 9.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                               input logic c);
    logic [4:0] t;
    logic [4:0] adj;
    logic [4:0] res;
    t   = {1'b0, x} + {1'b0, y} + {4'd0, c};
    adj = t + 5'd6;
    if (t > 5'd9) begin
      res = {1'b1, adj[3:0]};
    end else begin
      res = {1'b0, t[3:0]};
    end
    return res;
  endfunction

  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  assign w_base   = {r_cnt, 2'b00};
  assign w_a_dig  = r_a[w_base +: 4];
  assign w_b_dig  = r_b[w_base +: 4];
`ifdef BCD_SUB_EN
  assign w_b_eff  = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
`else
  assign w_b_eff  = w_b_dig;
`endif
  assign w_res    = bcd_digit_add(w_a_dig, w_b_eff, r_carry);
  assign w_bad    = digit_invalid(w_a_dig) | digit_invalid(w_b_dig);
  assign w_last   = (r_cnt == LAST_DIGIT);
  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nx = S_RUN;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they track r_state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nx == S_IDLE);
      r_out_valid <= (w_state_nx == S_DONE);
      r_busy      <= (w_state_nx != S_IDLE);
    end
  end

  // Operand latch and per-digit datapath; the counter parks on the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
`ifdef BCD_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
`ifdef BCD_SUB_EN
      r_sub   <= bus.sub;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
`else
      r_carry <= bus.cin;
`endif
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: 4] <= w_res[3:0];
      r_carry            <= w_res[4];
      r_err              <= r_err | w_bad;
      if (w_last) begin
        r_cout <= w_res[4];
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed + scoreboarded bench for bcd_serial_add_ctrl (DIGITS=4).
module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
`ifdef BCD_SUB_EN
  logic sub_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bif ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Present operands, wait for the accepting edge, then scramble the inputs.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic push, input exp_t e);
    int n;
    n = 0;
    while (bif.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    bif.a        = a;
    bif.b        = b;
    bif.cin      = cin;
`ifdef BCD_SUB_EN
    bif.sub      = sub_mode;
`endif
    bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    bif.a        = 16'($urandom);
    bif.b        = 16'($urandom);
    bif.cin      = ~cin;
    check("busy_run", 32'({bif.busy, bif.in_ready, bif.out_valid}), 32'(3'b100));
    if (push) sb_q.push_back(e);
  endtask

  // Wait for a result, optionally stall it (poking in_valid meanwhile), then compare.
  task automatic recv(input int hold, input int exp_lat, input logic poke);
    int   n;
    exp_t got;
    exp_t e;
    n = 0;
    while (bif.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (bif.out_valid !== 1'b1) begin
      check("recv_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(n), 32'(exp_lat));
    got = {bif.sum, bif.cout, bif.err};
    if (poke) begin
      bif.a        = 16'h1111;
      bif.b        = 16'h2222;
      bif.cin      = 1'b0;
      bif.in_valid = 1'b1;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_stable", 32'({bif.sum, bif.cout, bif.err}), 32'(got));
      check("hold_in_ready", 32'({bif.in_ready, bif.out_valid}), 32'(2'b01));
    end
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    check("ret_idle", 32'({bif.in_ready, bif.out_valid, bif.busy}), 32'(3'b100));
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("sum", 32'(got.s), 32'(e.s));
      check("cout", 32'(got.c), 32'(e.c));
      check("err", 32'(got.e), 32'(e.e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   ai;
    int   bi;
    int   ci;
    int   tot;
    exp_t ex;

    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.a         = 16'h0;
    bif.b         = 16'h0;
    bif.cin       = 1'b0;
`ifdef BCD_SUB_EN
    bif.sub       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_flags", 32'({bif.in_ready, bif.out_valid, bif.busy}), 32'(3'b100));
    check("rst_data", 32'({bif.sum, bif.cout, bif.err}), 32'd0);

    send(16'h1234, 16'h4321, 1'b0, 1'b1, '{s: 16'h5555, c: 1'b0, e: 1'b0});
    recv(0, 4, 1'b0);
    send(16'h9999, 16'h0001, 1'b0, 1'b1, '{s: 16'h0000, c: 1'b1, e: 1'b0});
    recv(0, 4, 1'b0);
    send(16'h00A0, 16'h0000, 1'b0, 1'b1, '{s: 16'h0100, c: 1'b0, e: 1'b1});
    recv(0, 4, 1'b0);
    send(16'h0999, 16'h0000, 1'b1, 1'b1, '{s: 16'h1000, c: 1'b0, e: 1'b0});
    recv(0, 4, 1'b0);

    // Backpressure: stalled result, ignored in_valid, then the held request is taken.
    send(16'h0001, 16'h0002, 1'b0, 1'b1, '{s: 16'h0003, c: 1'b0, e: 1'b0});
    recv(5, 4, 1'b1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    sb_q.push_back('{s: 16'h3333, c: 1'b0, e: 1'b0});
    check("bp_accept", 32'({bif.in_ready, bif.busy}), 32'(2'b01));
    recv(0, 4, 1'b0);

    // Abort after two digits; nothing may come out for that operation.
    send(16'h5555, 16'h5555, 1'b0, 1'b0, '{s: 16'h0, c: 1'b0, e: 1'b0});
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_flags", 32'({bif.in_ready, bif.out_valid, bif.busy}), 32'(3'b100));
    check("abort_data", 32'({bif.sum, bif.cout, bif.err}), 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_out", 32'(bif.out_valid), 32'd0);
    end

    for (int r = 0; r < 4; r++) begin
      ai  = int'($urandom_range(0, 9999));
      bi  = int'($urandom_range(0, 9999));
      ci  = int'($urandom_range(0, 1));
      tot = ai + bi + ci;
      ex  = '{s: int2bcd(tot % 10000), c: (tot >= 10000), e: 1'b0};
      send(int2bcd(ai), int2bcd(bi), ci[0], 1'b1, ex);
      recv(r, 4, 1'b0);
      check("model_roundtrip", 32'(bcd2int(int2bcd(ai))), 32'(ai));
    end

`ifdef BCD_SUB_EN
    sub_mode = 1'b1;
    send(16'h0500, 16'h0123, 1'b0, 1'b1, '{s: 16'h0377, c: 1'b1, e: 1'b0});
    recv(0, 4, 1'b0);
    send(16'h0123, 16'h0500, 1'b1, 1'b1, '{s: 16'h9623, c: 1'b0, e: 1'b0});
    recv(0, 4, 1'b0);
    sub_mode = 1'b0;
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Digit-serial controller for multi-digit BCD addition. It accepts two packed BCD operands over a valid/ready handshake. It then sequences a single shared one-digit BCD adder stage across all digits, least-significant digit first, with a registered inter-digit carry. It returns the packed decimal result with carry-out and an invalid-digit flag. It is the area-saving alternative to a parallel ripple of per-digit BCD full adders.

Parameters:
DIGITS, 4, number of BCD digits per operand; legal range 1..16; operand width is 4*DIGITS.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and cin are valid.
in_ready  output  1  block can accept operands.
a  input  4*DIGITS  BCD operand A, digit 0 in bits [3:0].
b  input  4*DIGITS  BCD operand B.
cin  input  1  decimal carry into digit 0.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
sum  output  4*DIGITS  BCD result.
cout  output  1  decimal carry out of digit DIGITS-1.
err  output  1  at least one operand digit was greater than 9.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface is fixed: one clock `clk`; `rst` is a synchronous, active-high reset.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset values: state IDLE, sum=0, cout=0, err=0, carry register 0, digit counter 0. Consequently in_ready=1, out_valid=0, busy=0.
- Reset is honoured in any state, including mid-RUN. A partial result is discarded; nothing is emitted.
- IDLE→RUN on in_valid && in_ready:
  - latch a, b and cin into operand registers;
  - counter=0, err=0, sum=0.
- RUN processes one digit per cycle (digit i = counter):
  - t = a_i + b_i + carry (5-bit).
  - If t > 9: sum_i = (t+6)[3:0], carry=1. Otherwise sum_i = t[3:0], carry=0.
  - If a_i > 9 or b_i > 9, err is set sticky for this operation. The digit is still processed by the same rule.
  - Counter increments. On the edge processing digit DIGITS-1, go to DONE and cout takes the final carry.
- Latency: out_valid rises exactly DIGITS clock edges after the accepting edge. Example: DIGITS=4 gives acceptance at edge E0 and out_valid high after E4.
- DONE: sum, cout and err are held stable while out_ready=0 (unbounded backpressure).
  - On out_valid && out_ready, go to IDLE. in_ready is 1 in the following cycle.
  - There is no same-cycle result-accept/operand-accept overlap: throughput is one operation per DIGITS+2 cycles minimum.
- in_valid while not in IDLE is ignored. Operands are not sampled.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- DIGITS=1: RUN lasts one cycle.
- The counter is sized to ceil(log2(DIGITS)), minimum 1 bit. The counter must not wrap within an operation.
- sum, cout and err outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro BCD_SUB_EN.
- Defined:
  - Adds input port `sub` (1 bit), latched at acceptance.
  - When sub=1, each b digit is replaced by its nines complement (9 - b_i) before the add, and the initial carry is forced to 1 (cin ignored). This computes the ten's-complement difference a - b.
  - In subtract mode, cout=1 means no borrow (a >= b). cout=0 means the result is the ten's complement of the negative magnitude.
  - With sub=1, err is also set when b_i > 9. The complement of such a digit is taken modulo 16 in 4 bits.
- Undefined: no `sub` port, and the block always adds.

Test Plan:
- DIGITS=4, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, err=0; out_valid rises 4 edges after acceptance.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1, err=0. Also a=0x0999, b=0x0000, cin=1 → sum=0x1000, cout=0.
- Invalid digit: a=0x00A0, b=0x0000, cin=0 → sum=0x0100, cout=0, err=1. The next valid operation clears err.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/cout/err stable, in_ready=0, and a new in_valid is ignored. Raise out_ready → IDLE next cycle, then accept the new operands.
- Reset mid-operation: assert rst after 2 digits processed → next cycle IDLE, out_valid=0, in_ready=1, sum=0. No result emitted for the aborted operation.
- BCD_SUB_EN defined: a=0x0500, b=0x0123, sub=1 → sum=0x0377, cout=1. a=0x0123, b=0x0500, sub=1 → sum=0x9623, cout=0.
